// File: rtl/note_sequencer.sv
// Song playback controller and live-key arbiter; the only driver of the
// buzzer decoder's note code. Timing is built from a prescaled duration tick.
module note_sequencer #(
  parameter int unsigned TICK_DIV  = 500000,
  parameter int unsigned GAP_TICKS = 2
) (
  input  logic        iClk,
  input  logic        iReset,
  input  logic [7:0]  iKeyNote,
  input  logic        iPlay,
  input  logic        iStop,
  output logic [7:0]  oSongAddr,
  input  logic [15:0] iSongData,
  output logic [7:0]  oFreqType,
  output logic        oBusy,
  output logic        oDone
);

  localparam int unsigned PRESC_W = $clog2(TICK_DIV);
  localparam int unsigned CODE_W  = 8;
  localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_DIV - 1);
  localparam logic [CODE_W-1:0]  GAP_LAST   = CODE_W'(GAP_TICKS);
  localparam logic [CODE_W-1:0]  SILENCE    = 8'd100;
  localparam logic [CODE_W-1:0]  NOTE_MIN   = 8'd1;
  localparam logic [CODE_W-1:0]  NOTE_MAX   = 8'd59;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_LOAD,
    S_PLAY,
    S_GAP,
    S_DONE
  } state_e;

  state_e              state_q, state_d;
  logic [PRESC_W-1:0]  presc_q, presc_d;
  logic [CODE_W-1:0]   tcnt_q, tcnt_d;
  logic [CODE_W-1:0]   dur_q, dur_d;
  logic [CODE_W-1:0]   note_q, note_d;
  logic [CODE_W-1:0]   addr_q, addr_d;
  logic [CODE_W-1:0]   freq_q, freq_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;

  logic                key_valid;
  logic                tick;
  logic [CODE_W-1:0]   tcnt_inc;
  logic [CODE_W-1:0]   song_note;

  // Decode helpers shared by the FSM and the output mux
  always_comb begin
    key_valid = (iKeyNote >= NOTE_MIN) && (iKeyNote <= NOTE_MAX);
    song_note = ((note_q >= NOTE_MIN) && (note_q <= NOTE_MAX)) ? note_q : SILENCE;
    tick      = (presc_q == PRESC_LAST);
    tcnt_inc  = tcnt_q + 8'd1;
  end

  // Next-state, counters and registered-output inputs
  always_comb begin
    state_d = state_q;
    presc_d = presc_q;
    tcnt_d  = tcnt_q;
    dur_d   = dur_q;
    note_d  = note_q;
    addr_d  = addr_q;

    case (state_q)
      S_IDLE: begin
        if (iPlay && !iStop) state_d = S_FETCH;
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        if (iSongData[7:0] == 8'd0) begin
          state_d = S_DONE;
        end else begin
          note_d  = iSongData[15:8];
          dur_d   = iSongData[7:0];
          presc_d = '0;
          tcnt_d  = '0;
          state_d = S_PLAY;
        end
      end
      S_PLAY: begin
        // A held key freezes the note timer so playback resumes cycle-exact
        if (!key_valid) begin
          if (tick) begin
            presc_d = '0;
            if (tcnt_inc == dur_q) begin
              tcnt_d  = '0;
              state_d = S_GAP;
            end else begin
              tcnt_d = tcnt_inc;
            end
          end else begin
            presc_d = presc_q + PRESC_W'(1);
          end
        end
      end
      S_GAP: begin
        if (!key_valid) begin
          if (tick) begin
            presc_d = '0;
            if (tcnt_inc == GAP_LAST) begin
              tcnt_d = '0;
              if (addr_q == 8'hFF) begin
                state_d = S_DONE;
              end else begin
                addr_d  = addr_q + 8'd1;
                state_d = S_FETCH;
              end
            end else begin
              tcnt_d = tcnt_inc;
            end
          end else begin
            presc_d = presc_q + PRESC_W'(1);
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (iStop && (state_q != S_IDLE)) state_d = S_IDLE;
    if (state_d == S_IDLE) addr_d = 8'd0;

    busy_d = state_d inside {S_FETCH, S_LOAD, S_PLAY, S_GAP};
    done_d = (state_d == S_DONE);
    freq_d = key_valid ? iKeyNote : ((state_q == S_PLAY) ? song_note : SILENCE);
  end

  always_ff @(posedge iClk or posedge iReset) begin
    if (iReset) begin
      state_q <= S_IDLE;
      presc_q <= '0;
      tcnt_q  <= '0;
      dur_q   <= '0;
      note_q  <= '0;
      addr_q  <= '0;
      freq_q  <= SILENCE;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      presc_q <= presc_d;
      tcnt_q  <= tcnt_d;
      dur_q   <= dur_d;
      note_q  <= note_d;
      addr_q  <= addr_d;
      freq_q  <= freq_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign oSongAddr = addr_q;
  assign oFreqType = freq_q;
  assign oBusy     = busy_q;
  assign oDone     = done_q;

endmodule
